move_scheduler: RTL and testbench



---
 rtl/move_scheduler_if.sv | 28 ++
 rtl/move_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_move_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_if.sv
// Button, position and movement-strobe bundle between the board/tracker side and move_scheduler.
interface move_scheduler_if;
    logic       btnUp;
    logic       btnDown;
    logic       btnLeft;
    logic       btnRight;
    logic       auto_en;
    logic [8:0] CircleRow;
    logic [9:0] CircleCol;
    logic       movUp;
    logic       movDown;
    logic       movLeft;
    logic       movRight;
    logic       auto_active;
    logic       tick;

    // Board/tracker side: drives buttons and position, observes strobes.
    modport master (
        output btnUp, btnDown, btnLeft, btnRight, auto_en, CircleRow, CircleCol,
        input  movUp, movDown, movLeft, movRight, auto_active, tick
    );

    // Scheduler side.
    modport slave (
        input  btnUp, btnDown, btnLeft, btnRight, auto_en, CircleRow, CircleCol,
        output movUp, movDown, movLeft, movRight, auto_active, tick
    );
endinterface

// File: rtl/move_scheduler.sv
// Arbitrates the tracker's movement strobes between debounced buttons and an
// autonomous diagonal bounce; decisions are registered once per decision tick.
module move_scheduler #(
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned DEBOUNCE   = 500_000,
    parameter int unsigned IDLE_TICKS = 200,
    parameter int unsigned ROW_MIN    = 30,
    parameter int unsigned ROW_MAX    = 450,
    parameter int unsigned COL_MIN    = 30,
    parameter int unsigned COL_MAX    = 610
) (
    input  logic             clk50,
    input  logic             rst_n,
    move_scheduler_if.slave  bus
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned IW = $clog2(IDLE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_TICKS);
    localparam logic [8:0]    ROW_LO    = 9'(ROW_MIN);
    localparam logic [8:0]    ROW_HI    = 9'(ROW_MAX);
    localparam logic [9:0]    COL_LO    = 10'(COL_MIN);
    localparam logic [9:0]    COL_HI    = 10'(COL_MAX);

    typedef enum logic {ST_MANUAL, ST_AUTO} state_t;

    // Button vectors are ordered {right, left, down, up}.
    logic [3:0]    btn_raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;
    logic [DW-1:0] db_cnt [4];
    logic [TW-1:0] tick_cnt;
    logic          tick_c;

    state_t        state_q, state_d;
    logic          dir_v_q, dir_v_d;
    logic          dir_h_q, dir_h_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    mov_q, mov_d;
    logic          auto_q, auto_d;

    logic          any_btn;
    logic          cancel_v;
    logic          cancel_h;
    logic [3:0]    man_mov;
    logic          step_v;
    logic          step_h;
    logic [3:0]    auto_mov;

    assign btn_raw = {bus.btnRight, bus.btnLeft, bus.btnDown, bus.btnUp};
    assign tick_c  = (tick_cnt == TICK_LAST);

    // Two-stage synchronizer and per-button disagreement counter.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Free-running decision tick divider.
    always_ff @(posedge clk50) begin
        if (!rst_n)      tick_cnt <= '0;
        else if (tick_c) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    // Manual request with opposing buttons cancelling per axis.
    always_comb begin
        any_btn  = |db;
        cancel_v = db[0] ^ db[1];
        cancel_h = db[2] ^ db[3];
        man_mov  = {db[3] & cancel_h, db[2] & cancel_h, db[1] & cancel_v, db[0] & cancel_v};
    end

    // Bounce direction update from the sampled position; at most one flip per axis.
    always_comb begin
        step_v = dir_v_q;
        step_h = dir_h_q;
        if (dir_v_q && (bus.CircleRow >= ROW_HI))       step_v = 1'b0;
        else if (!dir_v_q && (bus.CircleRow <= ROW_LO)) step_v = 1'b1;
        if (dir_h_q && (bus.CircleCol >= COL_HI))       step_h = 1'b0;
        else if (!dir_h_q && (bus.CircleCol <= COL_LO)) step_h = 1'b1;
        auto_mov = {step_h, ~step_h, ~step_v, step_v};
    end

    // Arbitration state register.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            dir_v_q <= 1'b1;
            dir_h_q <= 1'b1;
            idle_q  <= '0;
            mov_q   <= '0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_v_q <= dir_v_d;
            dir_h_q <= dir_h_d;
            idle_q  <= idle_d;
            mov_q   <= mov_d;
            auto_q  <= auto_d;
        end
    end

    // Next-state and strobe decisions, evaluated only on the tick.
    always_comb begin
        state_d = state_q;
        dir_v_d = dir_v_q;
        dir_h_d = dir_h_q;
        idle_d  = idle_q;
        mov_d   = mov_q;
        auto_d  = auto_q;
        if (tick_c) begin
            case (state_q)
                ST_MANUAL: begin
                    if (any_btn) begin
                        mov_d  = man_mov;
                        idle_d = '0;
                    end else begin
                        mov_d = '0;
                        if ((idle_q >= IDLE_LAST) && bus.auto_en) begin
                            state_d = ST_AUTO;
                            dir_v_d = step_v;
                            dir_h_d = step_h;
                            mov_d   = auto_mov;
                            auto_d  = 1'b1;
                            idle_d  = '0;
                        end else if (idle_q != IDLE_SAT) begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                end
                ST_AUTO: begin
                    if (any_btn) begin
                        state_d = ST_MANUAL;
                        mov_d   = man_mov;
                        auto_d  = 1'b0;
                        idle_d  = '0;
                    end else if (!bus.auto_en) begin
                        state_d = ST_MANUAL;
                        mov_d   = '0;
                        auto_d  = 1'b0;
                        idle_d  = '0;
                    end else begin
                        dir_v_d = step_v;
                        dir_h_d = step_h;
                        mov_d   = auto_mov;
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end
    end

    assign bus.movUp       = mov_q[0];
    assign bus.movDown     = mov_q[1];
    assign bus.movLeft     = mov_q[2];
    assign bus.movRight    = mov_q[3];
    assign bus.auto_active = auto_q;
    assign bus.tick        = tick_c;
endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: a cycle model queues the expected
// strobes at each tick, a monitor pops and compares them after every tick edge.
module tb_move_scheduler;
    localparam int unsigned TD = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned IT = 5;

    logic clk50 = 1'b0;
    logic rst_n;
    always #5 clk50 = ~clk50;

    move_scheduler_if bus ();

    move_scheduler #(
        .TICK_DIV(TD), .DEBOUNCE(DB), .IDLE_TICKS(IT),
        .ROW_MIN(30), .ROW_MAX(450), .COL_MIN(30), .COL_MAX(610)
    ) dut (
        .clk50(clk50),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed strobes packed {auto_active, right, left, down, up}.
    function automatic logic [4:0] outs();
        return {bus.auto_active, bus.movRight, bus.movLeft, bus.movDown, bus.movUp};
    endfunction

    // ---------------- reference model ----------------
    logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0;
    int         m_cnt [4];
    int         m_tc = 0, m_idle = 0;
    bit         m_auto = 0, m_dv = 1, m_dh = 1;
    logic [3:0] m_mov = '0;
    logic [4:0] exp_q [$];

    task automatic model_tick();
        bit any, v, h, nv, nh;
        logic [3:0] man;
        any = |m_db;
        v   = m_db[0] ^ m_db[1];
        h   = m_db[2] ^ m_db[3];
        man = {m_db[3] & h, m_db[2] & h, m_db[1] & v, m_db[0] & v};
        nv  = m_dv;
        nh  = m_dh;
        if (m_dv && bus.CircleRow >= 9'd450)       nv = 0;
        else if (!m_dv && bus.CircleRow <= 9'd30)  nv = 1;
        if (m_dh && bus.CircleCol >= 10'd610)      nh = 0;
        else if (!m_dh && bus.CircleCol <= 10'd30) nh = 1;
        if (!m_auto) begin
            if (any) begin
                m_mov = man; m_idle = 0;
            end else begin
                m_mov = '0;
                if (m_idle >= IT - 1 && bus.auto_en) begin
                    m_auto = 1; m_dv = nv; m_dh = nh; m_idle = 0;
                    m_mov = {nh, !nh, !nv, nv};
                end else if (m_idle < IT) begin
                    m_idle++;
                end
            end
        end else if (any) begin
            m_auto = 0; m_mov = man; m_idle = 0;
        end else if (!bus.auto_en) begin
            m_auto = 0; m_mov = '0; m_idle = 0;
        end else begin
            m_dv = nv; m_dh = nh;
            m_mov = {nh, !nh, !nv, nv};
        end
    endtask

    // Model advances on every clock edge; decisions use the pre-edge debounced state.
    initial forever begin
        @(posedge clk50);
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_tc = 0; m_idle = 0;
            m_auto = 0; m_dv = 1; m_dh = 1; m_mov = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            exp_q.delete();
        end else begin
            if (m_tc == TD - 1) begin
                model_tick();
                exp_q.push_back({m_auto, m_mov});
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] !== m_db[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DB) begin
                        m_db[i]  = m_s2[i];
                        m_cnt[i] = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.btnRight, bus.btnLeft, bus.btnDown, bus.btnUp};
            m_tc = (m_tc == TD - 1) ? 0 : m_tc + 1;
        end
    end

    // ---------------- monitor ----------------
    bit         pending = 0;
    bit         r_prev  = 0;
    logic [4:0] last    = '0;
    logic [4:0] cur;
    logic [4:0] e;

    initial forever begin
        @(negedge clk50);
        cur = outs();
        if (!r_prev) begin
            check("rst_outs", 32'(cur), 32'b0);
            check("rst_tick", 32'(bus.tick), 32'b0);
            last = '0;
        end else if (pending) begin
            check("tick_sync", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tick_outs", 32'(cur), 32'(e));
            end
            check("excl_v", 32'(bus.movUp & bus.movDown), 32'b0);
            check("excl_h", 32'(bus.movLeft & bus.movRight), 32'b0);
            last = cur;
        end else begin
            check("hold", 32'(cur), 32'(last));
        end
        pending = bus.tick && rst_n;
        r_prev  = rst_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk50);
        #2;
    endtask

    // Returns at the falling edge just after the next tick edge.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!bus.tick && n < 4 * TD);
        check("tick_timeout", 32'(bus.tick), 32'd1);
        @(negedge clk50);
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        bus.btnUp = u; bus.btnDown = d; bus.btnLeft = l; bus.btnRight = r;
    endtask

    // btnLeft was just released: expect takeover on the 5th button-free tick.
    task automatic expect_takeover(input string tag);
        int k;
        k = 0;
        do begin
            wait_tick();
            k++;
        end while (bus.movLeft && k < 10);
        check({tag, "_release"}, 32'(bus.movLeft), 32'b0);
        check({tag, "_idle1"}, 32'(bus.auto_active), 32'b0);
        for (int t = 2; t < IT; t++) begin
            wait_tick();
            check({tag, "_idle"}, 32'(bus.auto_active), 32'b0);
        end
        wait_tick();
        check({tag, "_take"}, 32'(outs()), 32'b11001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int  n;
    bit  saw;

    initial begin
        rst_n = 1'b0;
        set_btn(1, 1, 1, 1);
        bus.auto_en   = 1'b0;
        bus.CircleRow = 9'd240;
        bus.CircleCol = 10'd320;

        // Reset with buttons pressed.
        cyc(10);
        check("reset_outs", 32'(outs()), 32'b0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!bus.tick && n < 20);
        check("first_tick", 32'(n), 32'(TD));
        @(negedge clk50);
        check("first_tick_mov", 32'(outs()), 32'b0);
        set_btn(0, 0, 0, 0);
        repeat (4) wait_tick();

        // Short glitch is ignored.
        cyc(1);
        bus.btnUp = 1'b1;
        cyc(2);
        bus.btnUp = 1'b0;
        saw = 0;
        repeat (16) begin
            @(negedge clk50);
            saw |= bus.movUp;
        end
        check("glitch_up", 32'(saw), 32'b0);

        // Held press: latency and one full tick of stable level.
        cyc(1);
        bus.btnUp = 1'b1;
        n = 0;
        while (!bus.movUp && n < 40) begin
            @(posedge clk50);
            #1;
            n++;
        end
        check("press_lat_min", 32'(n >= DB + 2), 32'd1);
        check("press_lat_max", 32'(n <= DB + 2 + TD), 32'd1);
        for (int i = 1; i < TD; i++) begin
            @(posedge clk50);
            #1;
            check("up_held", 32'(bus.movUp), 32'd1);
        end
        bus.btnUp = 1'b0;

        // Opposing vertical buttons cancel, horizontal passes.
        set_btn(1, 1, 0, 1);
        repeat (3) wait_tick();
        check("conflict", 32'(outs()), 32'b01000);
        set_btn(0, 0, 0, 0);

        // No takeover while auto is not permitted.
        saw = 0;
        repeat (20) begin
            wait_tick();
            saw |= bus.auto_active;
        end
        check("no_takeover", 32'(saw), 32'b0);

        // Clear idle with a left press, then expect takeover.
        bus.btnLeft = 1'b1;
        repeat (3) wait_tick();
        check("left_manual", 32'(outs()), 32'b00100);
        bus.auto_en = 1'b1;
        bus.btnLeft = 1'b0;
        expect_takeover("auto");

        // Bounce off each limit.
        bus.CircleRow = 9'd450;
        wait_tick();
        check("bounce_row_max", 32'(outs()), 32'b11010);
        bus.CircleRow = 9'd240;
        bus.CircleCol = 10'd610;
        wait_tick();
        check("bounce_col_max", 32'(outs()), 32'b10110);
        bus.CircleCol = 10'd30;
        wait_tick();
        check("bounce_col_min", 32'(outs()), 32'b11010);
        bus.CircleRow = 9'd30;
        wait_tick();
        check("bounce_row_min", 32'(outs()), 32'b11001);
        bus.CircleRow = 9'd240;
        bus.CircleCol = 10'd320;
        wait_tick();
        check("auto_mid", 32'(outs()), 32'b11001);

        // Button preempts auto, then auto resumes after the idle period.
        bus.btnLeft = 1'b1;
        n = 0;
        do begin
            wait_tick();
            n++;
        end while (bus.auto_active && n < 10);
        check("preempt", 32'(outs()), 32'b00100);
        bus.btnLeft = 1'b0;
        expect_takeover("resume");

        // Withdrawing permission drops back to manual with strobes low.
        bus.auto_en = 1'b0;
        wait_tick();
        check("auto_off", 32'(outs()), 32'b0);

        // Reset in the middle of a held manual move.
        bus.btnRight = 1'b1;
        repeat (3) wait_tick();
        check("right_held", 32'(outs()), 32'b01000);
        cyc(1);
        rst_n = 1'b0;
        cyc(3);
        check("mid_reset", 32'(outs()), 32'b0);
        rst_n = 1'b1;
        repeat (3) wait_tick();
        check("after_reset", 32'(outs()), 32'b01000);
        bus.btnRight = 1'b0;
        repeat (3) wait_tick();

        @(negedge clk50);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
